bus_master_if: RTL and testbench

Single-master initiator for the shared 8-bit peripheral bus (BUS_DATA / BUS_ADDR / BUS_WE). It accepts one read or write request at a time over a valid/ready handshake and runs the matching bus cycle. It inserts the turnaround cycle that registered-enable responders need, and returns read data with a one-cycle valid pulse. It sits between the processor/control logic and the memory-mapped peripherals, such as the status LED register at 0xC0.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_master_if.sv | 105 ++++++++++
 tb/tb_bus_master_if.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit peripheral bus: widths, address map and master FSM states.
package bus_pkg;

  localparam int unsigned BUS_WIDTH = 8;

  localparam logic [BUS_WIDTH-1:0] BUS_IDLE_ADDR   = 8'hFF;
  localparam logic [BUS_WIDTH-1:0] STATUS_LED_ADDR = 8'hC0;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StTurn
  } bus_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Single-master initiator for the shared 8-bit peripheral bus: one request at a time,
// fixed-latency reads followed by a turnaround cycle, single-cycle writes.
module bus_master_if
  import bus_pkg::*;
#(
  parameter int unsigned          READ_LATENCY = 2,
  parameter logic [BUS_WIDTH-1:0] IDLE_ADDR    = BUS_IDLE_ADDR
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WE,
  input  logic [BUS_WIDTH-1:0] REQ_ADDR,
  input  logic [BUS_WIDTH-1:0] REQ_WDATA,
  output logic                 RSP_VALID,
  output logic [BUS_WIDTH-1:0] RSP_RDATA,
  output logic                 BUSY,
  output logic [BUS_WIDTH-1:0] BUS_ADDR,
  output logic                 BUS_WE,
  inout  wire  [BUS_WIDTH-1:0] BUS_DATA
);

  localparam logic [3:0] ReadLat = READ_LATENCY[3:0];

  bus_state_e           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 data_oe;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          we_d    = REQ_WE;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          if (REQ_WE) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
            cnt_d   = 4'd1;
          end
        end
      end
      StWrite: state_d = StIdle;
      StRead: begin
        if (cnt_q < ReadLat) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          rsp_rdata_d = BUS_DATA;
          rsp_valid_d = 1'b1;
          state_d     = StTurn;
        end
      end
      // Responder's registered enable still drives the bus here; master stays off it.
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    REQ_READY = (state_q == StIdle) && RESET;
    BUSY      = (state_q != StIdle);
    BUS_ADDR  = ((state_q == StWrite) || (state_q == StRead)) ? addr_q : IDLE_ADDR;
    BUS_WE    = (state_q == StWrite) && we_q;
    data_oe   = (state_q == StWrite);
  end

  assign BUS_DATA  = data_oe ? wdata_q : {BUS_WIDTH{1'bz}};
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if with registered-enable responders at the status LED address.
module tb_bus_master_if;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nvec = 0;
  int unsigned nfail = 0;

  logic       rst_n;
  logic       req_valid, req_valid2;
  logic       req_we;
  logic [7:0] req_addr, req_wdata;

  logic       req_ready, rsp_valid, busy, bus_we;
  logic [7:0] rsp_rdata, bus_addr;
  wire  [7:0] bus_data;

  logic       req_ready2, rsp_valid2, busy2, bus_we2;
  logic [7:0] rsp_rdata2, bus_addr2;
  wire  [7:0] bus_data2;

  bus_master_if #(.READ_LATENCY(2), .IDLE_ADDR(8'hFF)) dut (
    .CLK(clk), .RESET(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .BUSY(busy),
    .BUS_ADDR(bus_addr), .BUS_WE(bus_we), .BUS_DATA(bus_data)
  );

  bus_master_if #(.READ_LATENCY(3), .IDLE_ADDR(8'hFF)) dut2 (
    .CLK(clk), .RESET(rst_n), .REQ_VALID(req_valid2), .REQ_READY(req_ready2),
    .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid2), .RSP_RDATA(rsp_rdata2), .BUSY(busy2),
    .BUS_ADDR(bus_addr2), .BUS_WE(bus_we2), .BUS_DATA(bus_data2)
  );

  // LED register responder: captures writes, drives reads one cycle after address decode.
  logic [7:0] led_q = 8'h00;
  logic       rsp_en_q = 1'b0;
  always @(posedge clk) begin
    if (bus_we && bus_addr == STATUS_LED_ADDR) led_q <= bus_data;
    rsp_en_q <= (bus_addr == STATUS_LED_ADDR) && !bus_we;
  end
  assign bus_data = rsp_en_q ? led_q : 8'hzz;

  // Slower responder for the latency-3 master: drives a constant two cycles after decode.
  logic en1_q = 1'b0;
  logic en2_q = 1'b0;
  always @(posedge clk) begin
    en1_q <= (bus_addr2 == STATUS_LED_ADDR) && !bus_we2;
    en2_q <= en1_q;
  end
  assign bus_data2 = en2_q ? 8'h81 : 8'hzz;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
    req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    step(); step();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus_addr, 8'hFF);
    chk("rst_we", bus_we, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_oe", dut.data_oe, 0);
    rst_n = 1'b1; #1;
    chk("rel_ready", req_ready, 1);

    // 1: single write
    req_valid = 1; req_we = 1; req_addr = 8'hC0; req_wdata = 8'hA5;
    step(); req_valid = 0;
    chk("w1_addr", bus_addr, 8'hC0);
    chk("w1_we", bus_we, 1);
    chk("w1_data", bus_data, 8'hA5);
    chk("w1_ready", req_ready, 0);
    chk("w1_busy", busy, 1);
    step();
    chk("w1_we_done", bus_we, 0);
    chk("w1_addr_idle", bus_addr, 8'hFF);
    chk("w1_ready_back", req_ready, 1);
    chk("w1_led", led_q, 8'hA5);

    // 2: write 3C then read it back
    req_valid = 1; req_we = 1; req_wdata = 8'h3C;
    step(); req_valid = 0;
    step();
    chk("w2_led", led_q, 8'h3C);
    req_valid = 1; req_we = 0;
    step(); req_valid = 0;
    chk("r2_e0_valid", rsp_valid, 0);
    chk("r2_e0_addr", bus_addr, 8'hC0);
    chk("r2_e0_ready", req_ready, 0);
    chk("r2_e0_oe", dut.data_oe, 0);
    step();
    chk("r2_e1_valid", rsp_valid, 0);
    step();
    chk("r2_e2_valid", rsp_valid, 1);
    chk("r2_e2_rdata", rsp_rdata, 8'h3C);
    chk("r2_e2_addr", bus_addr, 8'hFF);
    chk("r2_e2_ready", req_ready, 0);
    step();
    chk("r2_e3_valid", rsp_valid, 0);
    chk("r2_e3_ready", req_ready, 1);
    chk("r2_e3_rdata_hold", rsp_rdata, 8'h3C);

    // 3: read with a write held pending behind it
    req_valid = 1; req_we = 0; req_addr = 8'hC0;
    step();
    req_we = 1; req_wdata = 8'h5A;
    step();
    chk("r3_e1_we", bus_we, 0);
    step();
    chk("r3_turn_we", bus_we, 0);
    chk("r3_turn_oe", dut.data_oe, 0);
    chk("r3_turn_bus", bus_data, 8'h3C);
    chk("r3_turn_valid", rsp_valid, 1);
    step();
    chk("r3_e3_we", bus_we, 0);
    chk("r3_e3_addr", bus_addr, 8'hFF);
    chk("r3_e3_ready", req_ready, 1);
    step(); req_valid = 0;
    chk("r3_w_we", bus_we, 1);
    chk("r3_w_addr", bus_addr, 8'hC0);
    chk("r3_w_data", bus_data, 8'h5A);
    step();
    chk("r3_led", led_q, 8'h5A);
    chk("r3_we_done", bus_we, 0);

    // 4: reset during second read cycle
    req_valid = 1; req_we = 0;
    step(); req_valid = 0;
    step();
    rst_n = 1'b0;
    step();
    chk("r4_valid", rsp_valid, 0);
    chk("r4_addr", bus_addr, 8'hFF);
    chk("r4_we", bus_we, 0);
    chk("r4_oe", dut.data_oe, 0);
    chk("r4_ready_low", req_ready, 0);
    chk("r4_busy", busy, 0);
    chk("r4_rdata", rsp_rdata, 8'h00);
    rst_n = 1'b1; #1;
    chk("r4_ready_rel", req_ready, 1);
    step();
    chk("r4_valid_after", rsp_valid, 0);
    step();
    chk("r4_valid_after2", rsp_valid, 0);

    // 5: latency-3 master with slow responder
    req_valid2 = 1; req_we = 0; req_addr = 8'hC0;
    step(); req_valid2 = 0;
    chk("r5_busy", busy2, 1);
    step();
    step();
    chk("r5_e2_valid", rsp_valid2, 0);
    step();
    chk("r5_e3_valid", rsp_valid2, 1);
    chk("r5_e3_rdata", rsp_rdata2, 8'h81);
    step();
    chk("r5_e4_valid", rsp_valid2, 0);
    chk("r5_e4_ready", req_ready2, 1);

    // 6: back-to-back writes with valid held
    req_valid = 1; req_we = 1; req_addr = 8'hC0; req_wdata = 8'h01;
    step();
    req_wdata = 8'h02;
    chk("w6_0_we", bus_we, 1);
    chk("w6_0_data", bus_data, 8'h01);
    step();
    chk("w6_1_we", bus_we, 0);
    chk("w6_1_led", led_q, 8'h01);
    step();
    req_wdata = 8'h03;
    chk("w6_2_we", bus_we, 1);
    chk("w6_2_data", bus_data, 8'h02);
    step();
    chk("w6_3_we", bus_we, 0);
    step(); req_valid = 0;
    chk("w6_4_we", bus_we, 1);
    chk("w6_4_data", bus_data, 8'h03);
    step();
    chk("w6_led", led_q, 8'h03);
    chk("w6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
